// File: rtl/sdiv_pkg.sv
// sdiv_pkg: shared types and constants for the sequential signed divider.
// Holds the FSM state enum, default widths and the counter width helper.
package sdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } state_t;

   localparam int N_DEF = 12;
   localparam int M_DEF = 5;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sdiv_addsub.sv
// sdiv_addsub: W-bit ripple subtractor a - b built from full-adder cells.
// b is inverted and carry-in is 1; borrow_o is high when a < b.
module sdiv_addsub #(
   parameter int W = 6
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] diff_o,
   output logic         borrow_o
);

   logic [W:0] c;

   assign c[0] = 1'b1;

   for (genvar i = 0; i < W; i++) begin : g_fa
      logic bn;
      assign bn        = ~b_i[i];
      assign diff_o[i] = a_i[i] ^ bn ^ c[i];
      assign c[i+1]    = (a_i[i] & bn) | (a_i[i] & c[i]) | (bn & c[i]);
   end

   assign borrow_o = ~c[W];

endmodule

// File: rtl/sdiv_seq.sv
// sdiv_seq: sequential signed divider, restoring radix-2 on magnitudes.
// Optional zero-divisor early exit is enabled by defining SDIV_DZ_CHK_EN.
module sdiv_seq
   import sdiv_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [M-1:0] remainder,
   output logic         ovf,
   output logic         dz
);

   localparam int CW = cnt_w(N);

   state_t         state_q;
   logic [N-1:0]   dq_q;
   logic [M-1:0]   pr_q;
   logic [M-1:0]   dsr_q;
   logic [CW-1:0]  cnt_q;
   logic           dvd_neg_q;
   logic           dsr_neg_q;
   logic           dvd_min_q;
   logic           busy_q;
   logic           done_q;
   logic           ovf_q;
   logic [N-1:0]   quo_q;
   logic [M-1:0]   rem_q;

   logic           dvd_neg;
   logic           dsr_neg;
   logic [N-1:0]   dvd_mag;
   logic [M-1:0]   dsr_mag;
   logic [M:0]     pr_sh;
   logic [M:0]     diff;
   logic           borrow;
   logic           unused_diff_msb;
   logic [N-1:0]   quo_fix;
   logic [M-1:0]   rem_fix;
   logic           ovf_fix;

   assign dvd_neg = dividend[N-1];
   assign dsr_neg = divisor[M-1];
   assign dvd_mag = dvd_neg ? (~dividend + N'(1)) : dividend;
   assign dsr_mag = dsr_neg ? (~divisor + M'(1)) : divisor;

   // dq_q shifts dividend bits out of the top and quotient bits in below
   assign pr_sh = {pr_q, dq_q[N-1]};

   sdiv_addsub #(
      .W(M + 1)
   ) u_sub (
      .a_i     (pr_sh),
      .b_i     ({1'b0, dsr_q}),
      .diff_o  (diff),
      .borrow_o(borrow)
   );

   // a kept difference is below the divisor magnitude, so its MSB is 0
   assign unused_diff_msb = diff[M];

   assign quo_fix = (dvd_neg_q ^ dsr_neg_q) ? (~dq_q + N'(1)) : dq_q;
   assign rem_fix = dvd_neg_q ? (~pr_q + M'(1)) : pr_q;
   assign ovf_fix = dvd_min_q & dsr_neg_q & (dsr_q == M'(1));

`ifdef SDIV_DZ_CHK_EN
   logic dz_q;
`endif

   // Control FSM, iteration datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         dq_q      <= '0;
         pr_q      <= '0;
         dsr_q     <= '0;
         cnt_q     <= '0;
         dvd_neg_q <= 1'b0;
         dsr_neg_q <= 1'b0;
         dvd_min_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
`ifdef SDIV_DZ_CHK_EN
         dz_q      <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
`ifdef SDIV_DZ_CHK_EN
                  if (divisor == '0) begin
                     quo_q   <= '0;
                     rem_q   <= '0;
                     ovf_q   <= 1'b0;
                     dz_q    <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     dz_q    <= 1'b0;
`else
                  begin
`endif
                     dq_q      <= dvd_mag;
                     dsr_q     <= dsr_mag;
                     dvd_neg_q <= dvd_neg;
                     dsr_neg_q <= dsr_neg;
                     dvd_min_q <= dvd_neg && (dvd_mag == {1'b1, {(N-1){1'b0}}});
                     pr_q      <= '0;
                     cnt_q     <= '0;
                     ovf_q     <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= ITER;
                  end
               end
            end
            ITER: begin
               pr_q <= borrow ? pr_sh[M-1:0] : diff[M-1:0];
               dq_q <= {dq_q[N-2:0], ~borrow};
               if (cnt_q == CW'(N - 1)) begin
                  state_q <= FIX;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            FIX: begin
               quo_q   <= quo_fix;
               rem_q   <= rem_fix;
               ovf_q   <= ovf_fix;
               state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign ovf       = ovf_q;
`ifdef SDIV_DZ_CHK_EN
   assign dz        = dz_q;
`else
   assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_sdiv_seq.sv
// tb_sdiv_seq: directed table-driven bench for sdiv_seq (N=12, M=5).
// Covers signed cases, overflow, start-while-busy, back-to-back and reset abort.
module tb_sdiv_seq;

   localparam int N = 12;
   localparam int M = 5;
   localparam int LAT = N + 2;

   typedef struct {
      logic [N-1:0] a;
      logic [M-1:0] b;
      logic [N-1:0] q;
      logic [M-1:0] r;
      logic         ovf;
   } vec_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [M-1:0] remainder;
   logic         ovf;
   logic         dz;

   int checks;
   int failures;

   vec_t vecs[14];

   sdiv_seq #(
      .N(N),
      .M(M)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .quotient (quotient),
      .remainder(remainder),
      .ovf      (ovf),
      .dz       (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic launch(input logic [N-1:0] a, input logic [M-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = N'($urandom);
      divisor  = M'($urandom);
   endtask

   task automatic wait_done(input int budget, output int lat);
      lat = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int nd;

      checks   = 0;
      failures = 0;

      vecs[0]  = '{12'd100,  5'd7,    12'd14,  5'd2,   1'b0};
      vecs[1]  = '{12'hF9C,  5'd7,    12'hFF2, 5'h1E,  1'b0};
      vecs[2]  = '{12'd100,  5'h19,   12'hFF2, 5'd2,   1'b0};
      vecs[3]  = '{12'hF9C,  5'h19,   12'd14,  5'h1E,  1'b0};
      vecs[4]  = '{12'h800,  5'h1F,   12'h800, 5'd0,   1'b1};
      vecs[5]  = '{12'h800,  5'h10,   12'd128, 5'd0,   1'b0};
      vecs[6]  = '{12'h7FF,  5'd15,   12'd136, 5'd7,   1'b0};
      vecs[7]  = '{12'h800,  5'd15,   12'hF78, 5'h18,  1'b0};
      vecs[8]  = '{12'd7,    5'h10,   12'd0,   5'd7,   1'b0};
      vecs[9]  = '{12'd0,    5'd3,    12'd0,   5'd0,   1'b0};
      vecs[10] = '{12'd63,   5'h18,   12'hFF9, 5'd7,   1'b0};
      vecs[11] = '{12'hFFF,  5'd1,    12'hFFF, 5'd0,   1'b0};
      vecs[12] = '{12'h7FF,  5'h1F,   12'h801, 5'd0,   1'b0};
      vecs[13] = '{12'hFF9,  5'd2,    12'hFFD, 5'h1F,  1'b0};

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs",
          32'({busy, done, ovf, dz, remainder, quotient}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int k = 0; k < 14; k++) begin
         launch(vecs[k].a, vecs[k].b);
         chk($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
         wait_done(LAT + 10, lat);
         chk($sformatf("v%0d_latency", k), 32'(lat), 32'(LAT));
         chk($sformatf("v%0d_quotient", k), 32'(quotient), 32'(vecs[k].q));
         chk($sformatf("v%0d_remainder", k), 32'(remainder), 32'(vecs[k].r));
         chk($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vecs[k].ovf));
         chk($sformatf("v%0d_dz", k), 32'(dz), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_pulse", k), 32'(done), 32'd0);
      end

      // start while busy: second request at cycle 5 must be ignored
      launch(12'd100, 5'd7);
      lat = -1;
      nd  = 0;
      for (int i = 1; i <= 30; i++) begin
         start = (i == 5);
         if (i == 5) begin
            dividend = 12'd50;
            divisor  = 5'd5;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            nd++;
            if (lat < 0) lat = i;
         end
      end
      chk("busy_start_done_count", 32'(nd), 32'd1);
      chk("busy_start_latency", 32'(lat), 32'(LAT));
      chk("busy_start_quotient", 32'(quotient), 32'd14);
      chk("busy_start_remainder", 32'(remainder), 32'd2);

      // start during the DONE state is ignored
      launch(12'd100, 5'd7);
      repeat (LAT - 1) @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 12'd50;
      divisor  = 5'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_state_done", 32'(done), 32'd1);
      chk("done_state_quotient", 32'(quotient), 32'd14);
      @(posedge clk);
      #1;
      chk("done_state_start_ignored", 32'(busy), 32'd0);

      // back-to-back: request issued in the done cycle is accepted
      launch(12'd100, 5'd7);
      wait_done(LAT + 10, lat);
      chk("b2b_first_latency", 32'(lat), 32'(LAT));
      launch(12'd63, 5'h18);
      chk("b2b_second_busy", 32'(busy), 32'd1);
      wait_done(LAT + 10, lat);
      chk("b2b_second_latency", 32'(lat), 32'(LAT));
      chk("b2b_second_quotient", 32'(quotient), 32'hFF9);
      chk("b2b_second_remainder", 32'(remainder), 32'd7);

      // reset mid-operation aborts with no done pulse
      launch(12'd100, 5'd7);
      wait_done(LAT + 10, lat);
      launch(12'd100, 5'd7);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_abort_outputs",
          32'({busy, done, ovf, dz, remainder, quotient}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      nd  = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      chk("rst_abort_no_done", 32'(nd), 32'd0);
      launch(12'd63, 5'h18);
      wait_done(LAT + 10, lat);
      chk("post_rst_latency", 32'(lat), 32'(LAT));
      chk("post_rst_quotient", 32'(quotient), 32'hFF9);
      chk("post_rst_remainder", 32'(remainder), 32'd7);

`ifdef SDIV_DZ_CHK_EN
      @(posedge clk);
      #1;
      launch(12'd5, 5'd0);
      wait_done(LAT + 10, lat);
      chk("dz_latency", 32'(lat), 32'd1);
      chk("dz_flag", 32'(dz), 32'd1);
      chk("dz_quotient", 32'(quotient), 32'd0);
      chk("dz_remainder", 32'(remainder), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
